// File: rtl/bnn_pkg.sv
// Shared BNN definitions: default word width and packer/popcount state enum.
// Imported by the input packer and the downstream popcount stage.
package bnn_pkg;

  localparam int BNN_WEIGHT_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } bnn_state_e;

  // Fill counter width; one spare bit so count+1 never overflows.
  function automatic int bnn_count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bnn_input_packer.sv
// Packs a serial binarized pixel stream into WEIGHT_COUNT-bit words and
// forwards weight words. Optional BNN_PACKER_DOUBLE_BUF_EN: no ISSUE stall.
module bnn_input_packer
  import bnn_pkg::*;
#(
  parameter int   WEIGHT_COUNT = BNN_WEIGHT_COUNT,
  parameter logic PAD_BIT      = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    weight_valid,
  input  logic [WEIGHT_COUNT-1:0] weight_data,
  output logic                    weight_ready,
  input  logic                    bit_valid,
  input  logic                    bit_in,
  output logic                    bit_ready,
  input  logic                    flush,
  output logic                    weight_wr,
  output logic [WEIGHT_COUNT-1:0] weight_in,
  output logic                    input_plugin,
  output logic [WEIGHT_COUNT-1:0] pixels_in,
  output logic [15:0]             words_issued
);

  localparam int CW = bnn_count_width(WEIGHT_COUNT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(WEIGHT_COUNT - 1);

  bnn_state_e              state, state_next;
  cnt_t                    count, count_next;
  cnt_t                    wr_idx, pad_from;
  logic [WEIGHT_COUNT-1:0] shreg, shreg_next;
  logic                    bit_acc, weight_acc;
  logic                    last_bit, issue;

  // Handshake readiness; weights win over bits in IDLE
  always_comb begin
    weight_ready = 1'b0;
    bit_ready    = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          weight_ready = 1'b1;
          bit_ready    = !weight_valid;
        end
        FILL: bit_ready = 1'b1;
        ISSUE: begin
`ifdef BNN_PACKER_DOUBLE_BUF_EN
          bit_ready = 1'b1;
`else
          bit_ready = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign weight_acc = weight_valid & weight_ready;
  assign bit_acc    = bit_valid & bit_ready;
  assign wr_idx     = (state == ISSUE) ? '0 : count;
  assign last_bit   = bit_acc && (wr_idx == LAST);

  // Next state, fill count and pack register contents
  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    pad_from   = count;
    issue      = 1'b0;
    for (int i = 0; i < WEIGHT_COUNT; i++) begin
      if (bit_acc && wr_idx == cnt_t'(i)) shreg_next[i] = bit_in;
    end
    unique case (state)
      IDLE: begin
        if (bit_acc) begin
          state_next = FILL;
          count_next = cnt_t'(1);
        end
      end
      FILL: begin
        if (bit_acc) count_next = count + cnt_t'(1);
        if (flush && !last_bit) begin
          pad_from = count_next;
          for (int i = 0; i < WEIGHT_COUNT; i++) begin
            if (cnt_t'(i) >= pad_from) shreg_next[i] = PAD_BIT;
          end
          state_next = ISSUE;
          count_next = '0;
          issue      = 1'b1;
        end
      end
      ISSUE: begin
        // A bit here only arrives with double buffering
        state_next = bit_acc ? FILL : IDLE;
        count_next = bit_acc ? cnt_t'(1) : '0;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    if (last_bit) begin
      state_next = ISSUE;
      count_next = '0;
      issue      = 1'b1;
    end
  end

  // State, pack register and registered downstream strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      shreg        <= '0;
      weight_wr    <= 1'b0;
      weight_in    <= '0;
      input_plugin <= 1'b0;
      pixels_in    <= '0;
      words_issued <= '0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      shreg        <= shreg_next;
      weight_wr    <= weight_acc;
      input_plugin <= issue;
      if (weight_acc) weight_in <= weight_data;
      if (issue) begin
        pixels_in    <= shreg_next;
        words_issued <= words_issued + 16'd1;
      end
    end
  end

endmodule

// File: doc/bnn_input_packer.md
BNN_INPUT_PACKER -- requirements
Module: bnn_input_packer

Interface
REQ-001 SHALL have parameter WEIGHT_COUNT, default 32, giving the packed word width and the bits per issued word.
REQ-002 SHALL have parameter PAD_BIT, default 1'b0, giving the fill value for unfilled positions on flush.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, exactly as follows:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have the remaining ports, one per line (name  direction  width  meaning):
- weight_valid  in  1  upstream weight word present.
- weight_data  in  WEIGHT_COUNT  weight word.
- weight_ready  out  1  weight word accepted on a cycle where weight_valid is also high.
- bit_valid  in  1  binarized pixel bit present.
- bit_in  in  1  pixel bit.
- bit_ready  out  1  pixel bit accepted on a cycle where bit_valid is also high.
- flush  in  1  single-cycle request to close a partial word.
- weight_wr  out  1  registered one-cycle weight write strobe to the downstream popcount stage.
- weight_in  out  WEIGHT_COUNT  registered weight word.
- input_plugin  out  1  registered one-cycle pixel word strobe.
- pixels_in  out  WEIGHT_COUNT  registered packed pixel word.
- words_issued  out  16  count of input_plugin pulses since reset.

Function
REQ-005 SHALL implement the states IDLE (fill count 0), FILL (count 1..WEIGHT_COUNT-1) and ISSUE.
REQ-006 SHALL drive weight_ready high only in IDLE; a weight is accepted when weight_valid and weight_ready are both high.
REQ-007 SHALL, on weight acceptance, assert weight_wr for exactly the next cycle, with weight_in equal to the accepted weight_data; the state SHALL remain IDLE.
REQ-008 SHALL give weight priority in IDLE: while weight_valid is high, bit_ready SHALL be low.
REQ-009 SHALL drive bit_ready high in IDLE when weight_valid is low, and high in FILL.
REQ-010 SHALL place each accepted bit at index count, so the first bit lands in LSB position 0, and then increment count.
REQ-011 SHALL, on acceptance of the bit at index WEIGHT_COUNT-1, enter ISSUE and reset count to 0.
REQ-012 SHALL, in ISSUE, assert input_plugin for one cycle with the completed word on pixels_in, increment words_issued, and return to IDLE the following cycle.
REQ-013 SHALL keep the latency from the last bit accepted to input_plugin high at exactly 1 cycle.
REQ-014 SHALL never assert input_plugin in the same cycle as weight_wr.
REQ-015 SHALL, on flush in FILL, fill positions count..WEIGHT_COUNT-1 with PAD_BIT and enter ISSUE.
REQ-016 SHALL, when flush and an accepted bit coincide, store the bit first and then pad the remainder.
REQ-017 SHALL ignore flush in IDLE and in ISSUE.
REQ-018 SHALL hold pixels_in and weight_in at their last values when the corresponding strobe is low.
REQ-019 SHALL let words_issued wrap from 16'hFFFF to 16'h0000.

Reset
REQ-020 SHALL, on reset assertion, immediately set state=IDLE, count=0, and every output to 0 (weight_ready, bit_ready, weight_wr, input_plugin, weight_in, pixels_in, words_issued).
REQ-021 SHALL, on reset mid-FILL, discard the partial word with no input_plugin pulse; reset release SHALL take effect at the next clock edge.

Configuration
REQ-022 SHALL, when macro BNN_PACKER_DOUBLE_BUF_EN is defined, add a holding register so that ISSUE does not stall input:
- bit_ready stays high in ISSUE.
- Bits accepted during ISSUE go to index 0 of the next word.
- Two consecutive words are issued with no gap cycle.
- weight_ready stays low until count is 0 and no issue is pending.
REQ-023 SHALL, when the macro is undefined, hold bit_ready low for the single ISSUE cycle.

Structure
REQ-024 SHALL take the WEIGHT_COUNT default and the state enum (IDLE, FILL, ISSUE) from shared package bnn_pkg, which the popcount stage also uses.
REQ-025 SHALL be a single module with no sub-module; the shift/pack register is inline.

Verification
REQ-026 Weight load: weight_valid with weight_data=32'hA5A5A5A5 in IDLE -> weight_ready=1; the next cycle weight_wr=1 and weight_in=32'hA5A5A5A5.
REQ-027 Full word: 32 consecutive bits of pattern 1,0,1,0,... -> input_plugin exactly 1 cycle after the 32nd accept; pixels_in=32'h55555555; words_issued=1.
REQ-028 Flush: 5 bits of 1 followed by flush, with PAD_BIT=0 -> pixels_in=32'h0000001F; a following word starts at index 0.
REQ-029 Simultaneous events: weight_valid and bit_valid both high in IDLE -> weight accepted, bit_ready=0; the bit is accepted the next cycle.
REQ-030 Reset: reset asserted after 17 bits -> outputs 0 asynchronously; no input_plugin; the next 32 bits form a clean word.
REQ-031 Double buffer: with BNN_PACKER_DOUBLE_BUF_EN, stream 64 bits back-to-back -> bit_ready never low; two input_plugin pulses exactly 32 cycles apart; words_issued=2.
